// File: rtl/resp_misr_capture.sv
// Response-side MISR capture: folds each valid DUT response vector to 32 bits,
// compresses a bounded window into a signature and compares it against exp_sig.
module resp_misr_capture #(
    parameter int unsigned          DATA_W   = 330,
    parameter int unsigned          SIG_W    = 32,
    parameter logic [SIG_W-1:0]     POLY     = 32'h04C11DB7,
    parameter logic [SIG_W-1:0]     SEED     = 32'hFFFFFFFF,
    parameter int unsigned          SKIP_CYC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [31:0]        num_cycles,
    input  logic [SIG_W-1:0]   exp_sig,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               busy,
    output logic               done,
    output logic               match,
    output logic [SIG_W-1:0]   signature,
    output logic [31:0]        cycle_cnt
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SKIP    = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam int unsigned NSLICE = (DATA_W + 31) / 32;
    localparam int unsigned PAD_W  = NSLICE * 32;

    logic [1:0]         state;
    logic [31:0]        skip_cnt;
    logic [31:0]        num_lat;
    logic               match_q;
    logic [PAD_W-1:0]   padded;
    logic [SIG_W-1:0]   fold;
    logic [SIG_W-1:0]   sig_next;

    // Zero-pad to whole 32-bit slices, then XOR the slices together.
    always_comb begin
        padded = '0;
        padded[DATA_W-1:0] = in_data;
        fold = '0;
        for (int unsigned k = 0; k < NSLICE; k++) begin
            fold = fold ^ padded[32*k +: 32];
        end
    end

    always_comb begin
        sig_next = {signature[SIG_W-2:0], 1'b0} ^ fold;
        if (signature[SIG_W-1]) begin
            sig_next = sig_next ^ POLY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            signature <= SEED;
            cycle_cnt <= '0;
            skip_cnt  <= '0;
            num_lat   <= '0;
            match_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        num_lat   <= num_cycles;
                        signature <= SEED;
                        cycle_cnt <= '0;
                        skip_cnt  <= SKIP_CYC;
                        match_q   <= 1'b0;
                        if (SKIP_CYC != 0) begin
                            state <= ST_SKIP;
                        end else if (num_cycles == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_CAPTURE;
                        end
                    end
                end
                ST_SKIP: begin
                    if (abort) begin
                        state   <= ST_IDLE;
                        match_q <= 1'b0;
                    end else if (in_valid) begin
                        skip_cnt <= skip_cnt - 32'd1;
                        if (skip_cnt == 32'd1) begin
                            state <= (num_lat == '0) ? ST_DONE : ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (abort) begin
                        state   <= ST_IDLE;
                        match_q <= 1'b0;
                    end else if (in_valid) begin
                        signature <= sig_next;
                        cycle_cnt <= cycle_cnt + 32'd1;
                        if (cycle_cnt + 32'd1 == num_lat) begin
                            state <= ST_DONE;
                        end
                    end
                end
                default: begin
                    match_q <= (signature == exp_sig);
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    // match is live during the DONE cycle and held from the register afterwards.
    assign busy  = (state == ST_SKIP) || (state == ST_CAPTURE);
    assign done  = (state == ST_DONE);
    assign match = (state == ST_DONE) ? (signature == exp_sig) : match_q;

endmodule

// File: tb/tb_resp_misr_capture.sv
// Bench for resp_misr_capture: table-driven runs on three parameterisations plus
// hand-written abort/reset/restart sequences, checked through a scoreboard queue.
module tb_resp_misr_capture;

    logic         clk = 1'b0;
    logic         rst, start, abort, in_valid;
    logic [31:0]  num_cycles, exp_sig;
    logic [329:0] in_data;

    logic        busy_a, done_a, match_a, busy_b, done_b, match_b, busy_c, done_c, match_c;
    logic [31:0] sig_a, cnt_a, sig_b, cnt_b, sig_c, cnt_c;

    always #5 clk = ~clk;

    // a: default seed, no skip; b: zero seed, no skip; c: zero seed, default skip
    resp_misr_capture #(.SKIP_CYC(0)) u_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_cycles(num_cycles),
        .exp_sig(exp_sig), .in_valid(in_valid), .in_data(in_data), .busy(busy_a),
        .done(done_a), .match(match_a), .signature(sig_a), .cycle_cnt(cnt_a));
    resp_misr_capture #(.SEED(32'h0), .SKIP_CYC(0)) u_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_cycles(num_cycles),
        .exp_sig(exp_sig), .in_valid(in_valid), .in_data(in_data), .busy(busy_b),
        .done(done_b), .match(match_b), .signature(sig_b), .cycle_cnt(cnt_b));
    resp_misr_capture #(.SEED(32'h0)) u_c (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_cycles(num_cycles),
        .exp_sig(exp_sig), .in_valid(in_valid), .in_data(in_data), .busy(busy_c),
        .done(done_c), .match(match_c), .signature(sig_c), .cycle_cnt(cnt_c));

    int          sel;
    logic        m_done, m_busy, m_match;
    logic [31:0] m_sig, m_cnt;

    always_comb begin
        case (sel)
            1:       begin m_done = done_b; m_busy = busy_b; m_match = match_b; m_sig = sig_b; m_cnt = cnt_b; end
            2:       begin m_done = done_c; m_busy = busy_c; m_match = match_c; m_sig = sig_c; m_cnt = cnt_c; end
            default: begin m_done = done_a; m_busy = busy_a; m_match = match_a; m_sig = sig_a; m_cnt = cnt_a; end
        endcase
    end

    typedef struct {
        logic [31:0] sig;
        logic [31:0] cnt;
        logic        match;
    } exp_t;

    typedef struct {
        int           sel;
        logic [31:0]  num;
        int           nsamp;
        logic [329:0] d0, d1, d2;
        int           gap;
        logic [31:0]  exp_in;
        logic [31:0]  sig;
        logic [31:0]  cnt;
        logic         match;
    } vec_t;

    exp_t sbq[$];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, want);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (m_done === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("signature", m_sig, e.sig);
                chk("cycle_cnt", m_cnt, e.cnt);
                chk("match", {31'd0, m_match}, {31'd0, e.match});
                chk("busy_in_done", {31'd0, m_busy}, 32'd0);
            end
        end
    end

    function automatic logic [31:0] fold_m(input logic [329:0] d);
        logic [351:0] p;
        logic [31:0]  r;
        p = {22'd0, d};
        r = 32'd0;
        for (int i = 0; i < 11; i++) r = r ^ p[i*32 +: 32];
        return r;
    endfunction

    function automatic logic [31:0] misr_m(input logic [31:0] s, input logic [329:0] d);
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ fold_m(d);
    endfunction

    function automatic logic [329:0] rnd330();
        logic [351:0] t;
        for (int i = 0; i < 11; i++) t[i*32 +: 32] = $urandom;
        return t[329:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] s, input logic [31:0] c, input logic m);
        exp_t e;
        e.sig = s; e.cnt = c; e.match = m;
        sbq.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sbq.size() != 0; i++) tick();
        chk("done_timeout", sbq.size(), 32'd0);
        tick();
    endtask

    task automatic run(input vec_t v);
        sel = v.sel;
        exp_sig = v.exp_in;
        num_cycles = v.num;
        push_exp(v.sig, v.cnt, v.match);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < v.nsamp; i++) begin
            in_valid = 1'b1;
            in_data = (i == 0) ? v.d0 : (i == 1) ? v.d1 : v.d2;
            tick();
            in_valid = 1'b0;
            in_data = '1;
            if (i < v.nsamp - 1) begin
                for (int g = 0; g < v.gap; g++) begin
                    tick();
                    chk("busy_in_gap", {31'd0, m_busy}, 32'd1);
                end
            end
        end
        drain();
    endtask

    vec_t         vt[8];
    logic [329:0] one, b329, b320;
    logic [329:0] d[10];
    logic [31:0]  s;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        num_cycles = '0; exp_sig = '0; in_data = '0; sel = 0;
        one = '0;  one[0] = 1'b1;
        b329 = '0; b329[329] = 1'b1;
        b320 = '0; b320[320] = 1'b1;

        vt[0] = '{0, 32'd1, 1, '0,   '0,   '0,  0, 32'hFB3EE249, 32'hFB3EE249, 32'd1, 1'b1};
        vt[1] = '{1, 32'd2, 2, one,  one,  '0,  0, 32'h3,        32'h3,        32'd2, 1'b1};
        vt[2] = '{1, 32'd2, 2, one,  one,  '0,  3, 32'h3,        32'h3,        32'd2, 1'b1};
        vt[3] = '{1, 32'd1, 1, b329, '0,   '0,  0, 32'h0,        32'h200,      32'd1, 1'b0};
        vt[4] = '{1, 32'd1, 1, b320, '0,   '0,  0, 32'h1,        32'h1,        32'd1, 1'b1};
        vt[5] = '{2, 32'd1, 3, 330'd5, 330'd7, one, 0, 32'h1,    32'h1,        32'd1, 1'b1};
        vt[6] = '{2, 32'd1, 3, 330'd5, 330'd7, one, 0, 32'h2,    32'h1,        32'd1, 1'b0};
        vt[7] = '{0, 32'd0, 0, '0,   '0,   '0,  0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b1};

        tick(); tick();
        rst = 1'b0;
        chk("rst_busy",  {31'd0, busy_a},  32'd0);
        chk("rst_done",  {31'd0, done_a},  32'd0);
        chk("rst_match", {31'd0, match_a}, 32'd0);
        chk("rst_sig_a", sig_a, 32'hFFFFFFFF);
        chk("rst_sig_b", sig_b, 32'h0);
        chk("rst_cnt",   cnt_a, 32'd0);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            run(vt[i]);
        end

        // start pulsed mid-run is ignored
        do_reset();
        sel = 0;
        for (int i = 0; i < 10; i++) d[i] = rnd330();
        s = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) s = misr_m(s, d[i]);
        push_exp(s, 32'd3, 1'b1);
        exp_sig = s; num_cycles = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = d[i];
            if (i == 1) begin start = 1'b1; num_cycles = 32'd1; end
            tick();
            start = 1'b0;
        end
        in_valid = 1'b0;
        drain();

        // reset after 3 of 10 samples
        num_cycles = 32'd10; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin in_valid = 1'b1; in_data = d[i]; tick(); end
        in_valid = 1'b0;
        chk("mid_cnt", cnt_a, 32'd3);
        chk("mid_busy", {31'd0, busy_a}, 32'd1);
        do_reset();
        chk("rst_mid_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_mid_sig", sig_a, 32'hFFFFFFFF);
        chk("rst_mid_cnt", cnt_a, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("rst_no_done", {31'd0, done_a}, 32'd0);
            tick();
        end

        // abort after 3 of 10 samples keeps partial values
        num_cycles = 32'd10; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin in_valid = 1'b1; in_data = d[i]; tick(); end
        in_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy",  {31'd0, busy_a},  32'd0);
        chk("abort_cnt",   cnt_a, 32'd3);
        chk("abort_sig",   sig_a, s);
        chk("abort_match", {31'd0, match_a}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_done", {31'd0, done_a}, 32'd0);
            tick();
        end

        // clean run after abort
        s = misr_m(misr_m(32'hFFFFFFFF, d[3]), d[4]);
        vt[0] = '{0, 32'd2, 2, d[3], d[4], '0, 1, s, s, 32'd2, 1'b1};
        run(vt[0]);

        // start and abort together in IDLE: start wins
        s = misr_m(32'hFFFFFFFF, d[5]);
        push_exp(s, 32'd1, 1'b0);
        exp_sig = ~s; num_cycles = 32'd1; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("start_wins_busy", {31'd0, busy_a}, 32'd1);
        in_valid = 1'b1; in_data = d[5];
        tick();
        in_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/resp_misr_capture.md
Name: resp_misr_capture

Overview:
- Response-side companion to the LCG stimulus driver in the fuzz bench.
- Consumes the DUT's flattened output vector one cycle at a time and compresses a bounded capture window into a 32-bit MISR signature.
- Compares the signature against an expected value, so a cycle run reports a single match/mismatch instead of a full per-cycle trace dump.
- Sits between the DUT's out_flat and the bench's reporting logic; synthesizable so it can also live on-chip.

Parameters:
- DATA_W, 330: width of captured response vector.
- SIG_W, 32: signature width (fixed at 32; other values unsupported).
- POLY, 32'h04C11DB7: MISR feedback polynomial.
- SEED, 32'hFFFFFFFF: signature value loaded on start.
- SKIP_CYC, 2: valid samples discarded after start (covers reset/settle cycles).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a capture run
- abort  in  1  single-cycle pulse; cancels a run in progress
- num_cycles  in  32  samples to compress, latched on start
- exp_sig  in  32  expected signature, sampled in DONE
- in_valid  in  1  in_data holds a valid response sample this cycle
- in_data  in  DATA_W  DUT response vector
- busy  out  1  high in SKIP or CAPTURE
- done  out  1  one-cycle pulse when a run completes
- match  out  1  signature == exp_sig, updated with done and held
- signature  out  32  current/final MISR value
- cycle_cnt  out  32  samples compressed in the current/last run

Behaviour:
- Reset: rst high at a clock edge forces the following, regardless of state:
  - state=IDLE
  - busy=0, done=0, match=0
  - signature=SEED, cycle_cnt=0
  - internal skip counter=0
  - Reset mid-run discards the run; no done pulse.
- Fold: in_data is zero-padded to a multiple of 32 bits (11 slices for 330) and the 32-bit slices are XORed; slice k = bits [32k+31:32k].
- MISR step: sig_next = {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ fold(in_data).
- FSM states: IDLE, SKIP, CAPTURE, DONE.
- IDLE:
  - start: latch num_cycles, signature<=SEED, cycle_cnt<=0, skip counter<=SKIP_CYC.
  - Next state is SKIP; if SKIP_CYC==0, go directly to CAPTURE (or to DONE if num_cycles==0).
- SKIP:
  - Each cycle with in_valid decrements the skip counter; data is ignored.
  - When the counter goes 1->0, the next state is CAPTURE, or DONE if num_cycles==0.
  - Cycles without in_valid do not advance.
- CAPTURE:
  - Each cycle with in_valid applies one MISR step and increments cycle_cnt.
  - The valid sample that makes cycle_cnt == num_cycles moves to DONE; that sample is included.
  - in_valid low holds all state.
- DONE: lasts exactly one cycle.
  - done=1, match=(signature==exp_sig), busy=0.
  - Next state is IDLE.
  - signature, cycle_cnt and match hold until the next start or rst.
- Latency: done asserts on the cycle after the final sample's edge.
- start while busy or in DONE: ignored.
- abort while busy:
  - Return to IDLE; no done pulse.
  - match<=0; signature and cycle_cnt keep their partial values.
- abort and start in the same IDLE cycle: start wins. In a busy cycle, abort wins.
- in_valid during IDLE or DONE: ignored.
- cycle_cnt is 32-bit and does not wrap: runs end at num_cycles ≤ 2^32-1.

Test Plan:
1. Defaults, SKIP_CYC=0, start with num_cycles=1, one sample in_data=0 -> done after 1 valid, signature=32'hFB3EE249, cycle_cnt=1.
2. SEED=0, SKIP_CYC=0, num_cycles=2, in_data=1 for two valid cycles -> signature=32'h00000003.
   - Repeat with in_valid low for 3 cycles between the samples -> same signature; busy stays high throughout.
3. SEED=0, SKIP_CYC=0, num_cycles=1:
   - in_data with only bit 329 set -> signature=32'h00000200.
   - in_data with only bit 320 set -> signature=32'h00000001 (checks fold/padding).
4. Default SKIP_CYC=2, SEED=0, num_cycles=1, samples 5,7,1 -> first two discarded, signature=32'h00000001.
   - With exp_sig=1: match=1 with done. With exp_sig=2: match=0.
5. num_cycles=0, SKIP_CYC=0 -> done on the cycle after start, signature=SEED, cycle_cnt=0.
   - Separately: start pulsed again while busy -> no restart, counts unaffected.
6. rst or abort asserted after 3 of 10 samples:
   - rst -> busy=0, signature=SEED, no done.
   - abort -> busy=0, cycle_cnt=3, no done.
   - A subsequent start runs cleanly to done.
